l2_arbiter: RTL and testbench



---
 rtl/lc3b_types.sv | 22 ++
 rtl/l2_arbiter_if.sv | 39 +++
 rtl/l2_arbiter_control.sv | 75 +++++++
 rtl/l2_arbiter.sv | 62 ++++++
 tb/tb_l2_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b word/line types plus the L2 arbiter state and source encodings.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } l2_arb_state_t;

  typedef enum logic {
    ARB_ICACHE = 1'b0,
    ARB_DCACHE = 1'b1
  } l2_arb_src_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/l2_arbiter_if.sv
// Bundle of the I-cache, D-cache and L2 CPU-side ports seen by the L2 arbiter.
interface l2_arbiter_if;
  import lc3b_types::*;

  logic     icache_read;
  lc3b_word icache_address;
  logic     icache_resp;
  lc3b_line icache_rdata;

  logic     dcache_read;
  logic     dcache_write;
  lc3b_word dcache_address;
  lc3b_line dcache_wdata;
  logic     dcache_resp;
  lc3b_line dcache_rdata;

  logic     l2_read;
  logic     l2_write;
  lc3b_word l2_address;
  lc3b_line l2_wdata;
  logic     l2_resp;
  lc3b_line l2_rdata;

  // slave: the arbiter; master: the L1 caches and L2 around it
  modport slave (
    input  icache_read, icache_address, dcache_read, dcache_write,
           dcache_address, dcache_wdata, l2_resp, l2_rdata,
    output icache_resp, icache_rdata, dcache_resp, dcache_rdata,
           l2_read, l2_write, l2_address, l2_wdata
  );

  modport master (
    output icache_read, icache_address, dcache_read, dcache_write,
           dcache_address, dcache_wdata, l2_resp, l2_rdata,
    input  icache_resp, icache_rdata, dcache_resp, dcache_rdata,
           l2_read, l2_write, l2_address, l2_wdata
  );

endinterface

// File: rtl/l2_arbiter_control.sv
// Arbiter FSM, last-grant tracking and tie-break. Round-robin ties when
// L2_ARB_ROUND_ROBIN_EN is defined, otherwise the D-cache wins every tie.
module l2_arbiter_control
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_req,
  input  logic        dcache_req,
  input  logic        l2_resp,
  output logic        grant_load,
  output l2_arb_src_t grant_src,
  output logic        serving
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_SERVE_I = SERVE_I;
  localparam logic [1:0] ST_SERVE_D = SERVE_D;
  localparam logic [1:0] ST_RECOVER = RECOVER;

  logic [1:0]  state_reg, state_next;
  l2_arb_src_t last_grant_reg;
  l2_arb_src_t tie_src;

`ifdef L2_ARB_ROUND_ROBIN_EN
  assign tie_src = (last_grant_reg == ARB_ICACHE) ? ARB_DCACHE : ARB_ICACHE;
`else
  // Fixed priority still tracks last_grant; it just never steers a tie.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_reg;
  assign tie_src = ARB_DCACHE;
`endif

  always_comb begin
    if (icache_req && dcache_req)
      grant_src = tie_src;
    else if (dcache_req)
      grant_src = ARB_DCACHE;
    else
      grant_src = ARB_ICACHE;
  end

  always_comb begin
    state_next = state_reg;
    grant_load = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (icache_req || dcache_req) begin
          grant_load = 1'b1;
          state_next = (grant_src == ARB_DCACHE) ? ST_SERVE_D : ST_SERVE_I;
        end
      end
      ST_SERVE_I, ST_SERVE_D: begin
        if (l2_resp)
          state_next = ST_RECOVER;
      end
      ST_RECOVER: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  assign serving = (state_reg == ST_SERVE_I) || (state_reg == ST_SERVE_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= ARB_ICACHE;
    end else begin
      state_reg <= state_next;
      if (grant_load)
        last_grant_reg <= grant_src;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the unified L2 between the I- and D-caches, one transaction at a time.
// Tie policy selected by L2_ARB_ROUND_ROBIN_EN (see l2_arbiter_control).
module l2_arbiter
  import lc3b_types::*;
(
  input logic         clk,
  input logic         rst,
  l2_arbiter_if.slave bus
);

  logic        grant_load;
  l2_arb_src_t grant_src;
  logic        serving;

  lc3b_word    addr_q;
  lc3b_line    wdata_q;
  logic        op_q;
  l2_arb_src_t src_q;

  l2_arbiter_control u_control (
    .clk        (clk),
    .rst        (rst),
    .icache_req (bus.icache_read),
    .dcache_req (bus.dcache_read | bus.dcache_write),
    .l2_resp    (bus.l2_resp),
    .grant_load (grant_load),
    .grant_src  (grant_src),
    .serving    (serving)
  );

  // Requester inputs are sampled only at grant, so later changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
      src_q   <= ARB_ICACHE;
    end else if (grant_load) begin
      src_q <= grant_src;
      if (grant_src == ARB_DCACHE) begin
        addr_q  <= bus.dcache_address;
        wdata_q <= bus.dcache_wdata;
        op_q    <= bus.dcache_write ? OP_WRITE : OP_READ;
      end else begin
        addr_q  <= bus.icache_address;
        wdata_q <= '0;
        op_q    <= OP_READ;
      end
    end
  end

  assign bus.l2_read    = serving && (op_q == OP_READ);
  assign bus.l2_write   = serving && (op_q == OP_WRITE);
  assign bus.l2_address = addr_q;
  assign bus.l2_wdata   = wdata_q;

  assign bus.icache_resp  = serving && bus.l2_resp && (src_q == ARB_ICACHE);
  assign bus.dcache_resp  = serving && bus.l2_resp && (src_q == ARB_DCACHE);
  assign bus.icache_rdata = bus.l2_rdata;
  assign bus.dcache_rdata = bus.l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: a scoreboard of expected L2 transactions is
// popped whenever the arbiter forwards a request, with a small L2 responder.
module tb_l2_arbiter;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_arbiter_if bus();

  l2_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    l2_arb_src_t src;
    logic [15:0] addr;
    logic        wr;
    logic [127:0] wdata;
  } txn_t;

  txn_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_iresp"}, bus.icache_resp, 1'b0);
    chk({tag, "_dresp"}, bus.dcache_resp, 1'b0);
    chk({tag, "_l2rd"},  bus.l2_read,     1'b0);
    chk({tag, "_l2wr"},  bus.l2_write,    1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.icache_read = 1'b0; bus.icache_address = '0;
    bus.dcache_read = 1'b0; bus.dcache_write = 1'b0;
    bus.dcache_address = '0; bus.dcache_wdata = '0;
    bus.l2_resp = 1'b0; bus.l2_rdata = '0;
    sb.delete();
    tick(); tick();
    chk_quiet("reset");
    chk("reset_addr",  bus.l2_address, 16'h0);
    chk("reset_wdata", bus.l2_wdata,   128'h0);
    rst = 1'b0;
  endtask

  // Waits for the forwarded request, checks it against the scoreboard, answers
  // after lat cycles and checks routing of the response and the RECOVER cycle.
  task automatic serve(input string tag, input int lat, input logic [127:0] rd,
                       input logic mutate, output int waited);
    txn_t e;
    waited = 0;
    while (!(bus.l2_read || bus.l2_write) && waited < 20) begin
      tick();
      waited++;
    end
    if (!(bus.l2_read || bus.l2_write) || sb.size() == 0) begin
      chk({tag, "_grant"}, {bus.l2_read | bus.l2_write, 32'(sb.size())}, {1'b1, 32'd1});
      return;
    end
    e = sb.pop_front();
    chk({tag, "_addr"}, bus.l2_address, e.addr);
    chk({tag, "_wr"},   bus.l2_write,   e.wr);
    chk({tag, "_rd"},   bus.l2_read,    !e.wr);
    if (e.wr) chk({tag, "_wdata"}, bus.l2_wdata, e.wdata);
    if (mutate) begin
      bus.dcache_address = 16'hFFFF;
      bus.dcache_wdata   = '1;
      bus.icache_address = 16'hEEEE;
    end
    for (int k = 0; k < lat; k++) begin
      tick();
      chk({tag, "_hold_addr"}, bus.l2_address, e.addr);
      chk({tag, "_hold_op"}, {bus.l2_read, bus.l2_write, bus.icache_resp, bus.dcache_resp},
          {!e.wr, e.wr, 2'b00});
    end
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = rd;
    #1;
    chk({tag, "_iresp"}, bus.icache_resp, e.src == ARB_ICACHE);
    chk({tag, "_dresp"}, bus.dcache_resp, e.src == ARB_DCACHE);
    chk({tag, "_rdata"}, (e.src == ARB_ICACHE) ? bus.icache_rdata : bus.dcache_rdata, rd);
    tick();
    bus.l2_resp = 1'b0;
    if (e.src == ARB_ICACHE) bus.icache_read = 1'b0;
    else begin
      bus.dcache_read  = 1'b0;
      bus.dcache_write = 1'b0;
    end
    #1;
    chk_quiet({tag, "_recover"});
  endtask

  int w;

  initial begin
    do_reset();

    // I-cache read, L2 answers 4 cycles after l2_read rises
    bus.icache_read = 1'b1; bus.icache_address = 16'h1230;
    sb.push_back('{ARB_ICACHE, 16'h1230, 1'b0, '0});
    serve("iread", 4, {8{16'hAAAA}}, 1'b0, w);
    chk("iread_lat", w, 1);

    // D-cache write with the address changing mid-transaction
    bus.dcache_write = 1'b1; bus.dcache_address = 16'h4560; bus.dcache_wdata = {8{16'h5555}};
    sb.push_back('{ARB_DCACHE, 16'h4560, 1'b1, {8{16'h5555}}});
    serve("dwrite", 3, {8{16'h0F0F}}, 1'b1, w);
    chk("dwrite_lat", w, 2);

    // illegal read+write is served as a write
    bus.dcache_read = 1'b1; bus.dcache_write = 1'b1;
    bus.dcache_address = 16'h7770; bus.dcache_wdata = {8{16'h1234}};
    sb.push_back('{ARB_DCACHE, 16'h7770, 1'b1, {8{16'h1234}}});
    serve("drw", 1, {8{16'h3C3C}}, 1'b0, w);

    // D-cache read
    bus.dcache_read = 1'b1; bus.dcache_address = 16'h2468;
    sb.push_back('{ARB_DCACHE, 16'h2468, 1'b0, '0});
    serve("dread", 2, {8{16'hBEEF}}, 1'b0, w);

    // stray l2_resp in IDLE
    tick();
    bus.l2_resp = 1'b1; bus.l2_rdata = {8{16'hDEAD}};
    #1;
    chk_quiet("ghost");
    tick();
    bus.l2_resp = 1'b0;
    bus.icache_read = 1'b1; bus.icache_address = 16'h0ABC;
    sb.push_back('{ARB_ICACHE, 16'h0ABC, 1'b0, '0});
    serve("ghost_after", 1, {8{16'h7777}}, 1'b0, w);
    chk("ghost_after_lat", w, 1);

    // back-to-back I-cache reads: second l2_read 3 cycles after first resp
    bus.icache_read = 1'b1; bus.icache_address = 16'h1111;
    sb.push_back('{ARB_ICACHE, 16'h1111, 1'b0, '0});
    serve("b2b_a", 2, {8{16'h1111}}, 1'b0, w);
    bus.icache_read = 1'b1; bus.icache_address = 16'h2222;
    sb.push_back('{ARB_ICACHE, 16'h2222, 1'b0, '0});
    serve("b2b_b", 1, {8{16'h2222}}, 1'b0, w);
    chk("b2b_gap", w, 2);

    // reset in the second cycle of SERVE_D
    bus.dcache_write = 1'b1; bus.dcache_address = 16'h3330; bus.dcache_wdata = {8{16'h9999}};
    tick(); tick();
    chk("rst_mid_wr", bus.l2_write, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.dcache_write = 1'b0;
    bus.l2_resp = 1'b1;
    #1;
    chk_quiet("rst_mid");
    chk("rst_mid_addr", bus.l2_address, 16'h0);
    tick();
    bus.l2_resp = 1'b0;
    bus.icache_read = 1'b1; bus.icache_address = 16'h5A5A;
    sb.push_back('{ARB_ICACHE, 16'h5A5A, 1'b0, '0});
    serve("rst_after", 1, {8{16'h4242}}, 1'b0, w);
    chk("rst_after_lat", w, 1);

    // simultaneous requests after reset, D re-requests straight away
    do_reset();
    bus.icache_read = 1'b1; bus.icache_address = 16'h1000;
    bus.dcache_read = 1'b1; bus.dcache_address = 16'h2000;
    sb.push_back('{ARB_DCACHE, 16'h2000, 1'b0, '0});
`ifdef L2_ARB_ROUND_ROBIN_EN
    sb.push_back('{ARB_ICACHE, 16'h1000, 1'b0, '0});
`endif
    serve("tie_1", 2, {8{16'hA1A1}}, 1'b0, w);
    chk("tie_1_lat", w, 1);
    bus.dcache_read = 1'b1; bus.dcache_address = 16'h2010;
    sb.push_back('{ARB_DCACHE, 16'h2010, 1'b0, '0});
`ifndef L2_ARB_ROUND_ROBIN_EN
    sb.push_back('{ARB_ICACHE, 16'h1000, 1'b0, '0});
`endif
    serve("tie_2", 1, {8{16'hB2B2}}, 1'b0, w);
    serve("tie_3", 1, {8{16'hC3C3}}, 1'b0, w);
    chk("tie_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
